// File: rtl/lfsr.sv
// lfsr: Fibonacci LFSR, widths 2..16, maximal-length taps, lock-up guarded.
module lfsr #(
  parameter int N    = 3,
  parameter int SEED = 1
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] out
);
  function automatic logic [15:0] tap_mask(input int n);
    case (n)
      2:       tap_mask = 16'h0003;
      3:       tap_mask = 16'h0006;
      4:       tap_mask = 16'h000C;
      5:       tap_mask = 16'h0014;
      6:       tap_mask = 16'h0030;
      7:       tap_mask = 16'h0060;
      8:       tap_mask = 16'h00B8;
      9:       tap_mask = 16'h0110;
      10:      tap_mask = 16'h0240;
      11:      tap_mask = 16'h0500;
      12:      tap_mask = 16'h0829;
      13:      tap_mask = 16'h100D;
      14:      tap_mask = 16'h2015;
      15:      tap_mask = 16'h6000;
      16:      tap_mask = 16'hD008;
      default: tap_mask = 16'h0000;
    endcase
  endfunction
  if (N < 2 || N > 16) begin : g_bad_n
    $error("lfsr: N=%0d outside legal range 2..16", N);
  end
  localparam logic [15:0]  MASK_ALL = tap_mask(N);
  localparam logic [N-1:0] MASK     = MASK_ALL[N-1:0];
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] SEED_N   = SEED[N-1:0];
  localparam logic [N-1:0] INIT     = (SEED_N == '0) ? ONE : SEED_N;
  logic [N-1:0] q, q_next;
  // All-zero is a fixed point of the shift, so force it back onto the cycle.
  always_comb q_next = (q == '0) ? ONE : {q[N-2:0], ^(q & MASK)};
  always_ff @(posedge clk) q <= reset ? INIT : q_next;
  assign out = q;
endmodule

// File: tb/tb_lfsr.sv
// tb_lfsr: directed checks of the N=3 sequence, reset, lock-up guard and N=8/16 periods.
module tb_lfsr;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  o3, o3b, o3z;
  logic [7:0]  o8;
  logic [15:0] o16;
  int          vectors = 0;
  int          miscompares = 0;
  logic [2:0]  seq [7] = '{3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100};
  always #5 clk = ~clk;
  lfsr #(.N(3),  .SEED(1)) u3  (.clk(clk), .reset(reset), .out(o3));
  lfsr #(.N(3),  .SEED(1)) u3b (.clk(clk), .reset(reset), .out(o3b));
  lfsr #(.N(3),  .SEED(0)) u3z (.clk(clk), .reset(reset), .out(o3z));
  lfsr #(.N(8),  .SEED(1)) u8  (.clk(clk), .reset(reset), .out(o8));
  lfsr #(.N(16), .SEED(1)) u16 (.clk(clk), .reset(reset), .out(o16));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int p8, p16, zeros;
    step();
    reset = 1'b0;
    check("rst_n3", 32'(o3), 1);
    check("rst_n3b", 32'(o3b), 1);
    check("rst_seed0", 32'(o3z), 1);
    check("rst_n8", 32'(o8), 1);
    check("rst_n16", 32'(o16), 1);
    for (int i = 1; i <= 7; i++) begin
      step();
      check("seq_n3", 32'(o3), 32'(seq[i % 7]));
      check("seq_n3b", 32'(o3b), 32'(seq[i % 7]));
      check("seq_seed0", 32'(o3z), 32'(seq[i % 7]));
    end
    for (int i = 8; i < 108; i++) begin
      step();
      check("run_n3", 32'(o3), 32'(seq[i % 7]));
      check("run_nonzero", 32'(o3 != 3'b000), 1);
    end
    for (int i = 0; i < 8 && o3 != 3'b111; i++) step();
    check("reach_111", 32'(o3), 32'h7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst", 32'(o3), 1);
    step();
    check("midrst_s1", 32'(o3), 2);
    step();
    check("midrst_s2", 32'(o3), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    p8 = 0;
    p16 = 0;
    zeros = 0;
    for (int c = 1; c <= 66000 && p16 == 0; c++) begin
      step();
      if (o8 == 8'd1 && p8 == 0) p8 = c;
      if (o16 == 16'd1 && p16 == 0) p16 = c;
      if (o8 == 8'd0 || o16 == 16'd0) zeros++;
    end
    check("period_n8", 32'(p8), 255);
    check("period_n16", 32'(p16), 65535);
    check("no_zero", 32'(zeros), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
